// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, baud divider and receiver FSM states.
package uart_pkg;

    // Byte width shared by the receiver and transmitter
    localparam int unsigned DATA_W = 8;

    // CLOCK_50 divider giving 115200 baud at 16 oversample ticks per bit
    localparam int unsigned CLKDIV_115200_OS16 = 27;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an asynchronous single-bit input, reset to RST_VAL.
module uart_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to compile in an even-parity bit (8E1 frame).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OS_RATE     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLK_OS,
    input  logic              RX_PIN,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              RX_FERR,
    output logic              RX_PERR,
    output logic              RX_BUSY
);

    localparam int unsigned CNT_W = $clog2(OS_RATE);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OS_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OS_RATE / 2);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(OS_RATE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic              rx_sync;
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        samp_q, samp_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif
    logic              vote;
    logic              bit_end;

    uart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (RX_PIN),
        .q     (rx_sync)
    );

    // Two stored mid-bit samples plus the live third sample; only meaningful at CNT_S2
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);
    assign bit_end = (cnt_q == CNT_END);

    // State, counters, shift register and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and datapath decode; everything advances only on CLK_OS
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (CLK_OS) begin
            if (state_q != IDLE && state_q != WAIT_HIGH) begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (cnt_q == CNT_S0) samp_d[0] = rx_sync;
                if (cnt_q == CNT_S1) samp_d[1] = rx_sync;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_S2 && vote) begin
                        state_d = IDLE;
                    end else if (bit_end) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_S2) shift_d = {vote, shift_q[DATA_W-1:1]};
                    if (bit_end) begin
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_S2) par_d = vote;
                    if (bit_end) state_d = STOP;
                end
`endif
                STOP: begin
                    // Leave at the vote, half a bit early, so a back-to-back start edge is not missed
                    if (cnt_q == CNT_S2) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~vote;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shift_q, par_q};
`endif
                        state_d = vote ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign RX_DATA  = data_q;
    assign RX_VALID = valid_q;
    assign RX_FERR  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign RX_PERR  = perr_q;
`else
    assign RX_PERR  = 1'b0;
`endif
    assign RX_BUSY  = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OS_RATE, default 16: oversample ticks per bit; legal values 8 or 16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops on RX_PIN; legal values 2 or 3.
REQ-003 CLK  in  1  system clock, 50 MHz (CLOCK_50); all logic on rising edge.
REQ-004 RST_N  in  1  synchronous, active-low reset; one clock, synchronous to CLK.
REQ-005 CLK_OS  in  1  oversample enable from clkdiv (divider 27 for 115200 baud at OS_RATE 16); one-CLK-wide pulse; not a clock.
REQ-006 RX_PIN  in  1  asynchronous serial line (UART_RXD); idle high.
REQ-007 RX_DATA  out  8  last received byte, LSB received first; held until the next frame completes.
REQ-008 RX_VALID  out  1  one-CLK pulse; RX_DATA, RX_FERR and RX_PERR are valid in that cycle.
REQ-009 RX_FERR  out  1  framing error flag; qualified by RX_VALID.
REQ-010 RX_PERR  out  1  parity error flag; qualified by RX_VALID.
REQ-011 RX_BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 RX_PIN shall pass through SYNC_STAGES flops; all later logic uses only the synchronised value.
REQ-013 FSM states shall be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the FSM, sample counter and bit counter advance only on CLK_OS.
REQ-014 IDLE -> START on the first CLK_OS with the synchronised line low; the sample counter clears to 0.
REQ-015 Each bit shall be decided by majority vote of the samples at counts OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1; the bit period ends at count OS_RATE-1 and the counter wraps to 0.
REQ-016 START: a voted 1 is a false start -> IDLE; no RX_VALID pulse and no flag; a voted 0 -> DATA at the end of the bit period.
REQ-017 DATA: 8 bits shall be shifted in LSB first; the bit counter runs 0..7; after bit 7 the FSM goes to PARITY if the parity feature is compiled in, otherwise to STOP.
REQ-018 STOP: at the vote decision, RX_DATA is loaded and RX_VALID pulses for exactly one CLK. RX_FERR = 1 if the voted stop bit is 0. RX_PERR is set as defined in REQ-024.
REQ-019 After STOP: if the stop bit is 1, the FSM goes to IDLE immediately, so the receiver is ready for a new start edge half a bit early. If the stop bit is 0 (break or framing error), the FSM goes to WAIT_HIGH and stays there until a CLK_OS samples the line high, then goes to IDLE.
REQ-020 Back-to-back frames with zero idle time shall be received without loss.
REQ-021 A CLK_OS pulse coinciding with a state transition shall be consumed exactly once; a missing CLK_OS stalls the FSM without corrupting state.
REQ-022 Latency: RX_VALID asserts within (9 + parity + 0.5) bit periods + (OS_RATE/2+1) ticks + SYNC_STAGES + 1 CLK after the falling start edge at the pin.

Reset
REQ-023 While RST_N = 0: FSM -> IDLE; counters, shift register and RX_DATA -> 0; RX_VALID, RX_FERR, RX_PERR and RX_BUSY -> 0; synchroniser flops -> 1. Reset mid-frame discards the partial frame with no pulse; reception restarts on the next start edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN, when defined, compiles in the PARITY state. One even-parity bit is voted after bit 7. RX_PERR = 1 if the XOR of the 8 data bits and the parity bit is 1. The frame is 8E1.
REQ-025 Without UART_RX_PARITY_EN, the PARITY state and its logic are absent, RX_PERR is tied to 0, and the frame is 8N1.

Structure
REQ-026 Package uart_pkg shall hold the FSM state enum typedef, the data width constant (8) and the divider constant for 115200 baud at OS_RATE 16 (27). uart_tx shall be able to share the data width constant.
REQ-027 One sub-module, uart_sync (an N-stage synchroniser with a reset-to-1 value), shall be instantiated for RX_PIN; all other logic is flat in uart_rx.

Verification
REQ-028 Frame 0x55 (8N1, 16 ticks/bit) -> one RX_VALID; RX_DATA = 0x55; RX_FERR = 0; RX_PERR = 0; RX_BUSY drops at the stop-bit vote.
REQ-029 3-tick low glitch on an idle line -> FSM returns to IDLE from START; no RX_VALID; RX_DATA keeps its previous value.
REQ-030 Frame 0xA3 with stop bit driven low for 2 bit times -> RX_VALID with RX_DATA = 0xA3 and RX_FERR = 1; no new frame starts before the line returns high.
REQ-031 Back-to-back 0x00 then 0xFF with zero idle, and frame timing ±3 % off nominal -> two RX_VALID pulses with the correct bytes and no flags.
REQ-032 RST_N pulsed low at data bit 4 of 0x3C -> no RX_VALID; all outputs 0; the next frame 0x81 is received correctly.
REQ-033 With UART_RX_PARITY_EN: frame 0x07 with parity bit 1 -> RX_PERR = 0; the same frame with parity bit 0 -> RX_PERR = 1.
